// File: rtl/gb_joypad_pkg.sv
// Shared Game Boy joypad constants: P1 address, select bit positions and IRQ bit.
// Also used by joypad_snes_adapter and the interrupt controller.
package gb_joypad_pkg;

  localparam logic [15:0] P1_ADDR_DEFAULT = 16'hFF00;
  localparam int          P14_BIT         = 4;
  localparam int          P15_BIT         = 5;
  localparam int          JOYPAD_IRQ_BIT  = 4;
  localparam logic [1:0]  SEL_NONE        = 2'b11;
  localparam int          NUM_LINES       = 4;

  // With no row selected the low nibble reads as all released.
  function automatic logic [7:0] p1_read_value(input logic [1:0] sel,
                                               input logic [NUM_LINES-1:0] rows);
    return {2'b11, sel, (sel == SEL_NONE) ? 4'hF : rows};
  endfunction

endpackage

// File: rtl/joypad_glitch_filter.sv
// One-bit debounce: the output follows d only after it has differed for FILTER_CYCLES samples.
module joypad_glitch_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic          raw;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      raw <= 1'b1;
      q   <= 1'b1;
      cnt <= '0;
    end else begin
      raw <= d;
      if (raw == q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        q   <= raw;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/joypad_p1_register.sv
// P1/JOYP register: bus decode, row select, debounced button readback and joypad IRQ.
// Edge detection is muted for a settle window after each select write.
module joypad_p1_register
  import gb_joypad_pkg::*;
#(
  parameter logic [15:0] P1_ADDR       = P1_ADDR_DEFAULT,
  parameter int          FILTER_CYCLES = 4,
  parameter int          SETTLE_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        wr,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic [1:0]  button_sel,
  input  logic [3:0]  button_data,
  output logic        int_req,
  input  logic        int_ack
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  logic [1:0]           sel_q;
  logic [SW-1:0]        settle;
  logic [NUM_LINES-1:0] filtered;
  logic [NUM_LINES-1:0] filtered_prev;
  logic                 wr_hit, rd_hit, irq_set;
  logic                 unused_din;

  assign wr_hit     = wr && (addr == P1_ADDR);
  assign rd_hit     = rd && (addr == P1_ADDR);
  assign button_sel = sel_q;
  assign unused_din = ^{din[7:6], din[3:0]};

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_filt
    joypad_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
      .clock (clock),
      .reset (reset),
      .d     (button_data[i]),
      .q     (filtered[i])
    );
  end

  // Falls during the settle window are dropped, not held for later.
  assign irq_set = (|(filtered_prev & ~filtered)) && (settle == '0) && (sel_q != SEL_NONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_q         <= SEL_NONE;
      settle        <= '0;
      filtered_prev <= '1;
      int_req       <= 1'b0;
      dout          <= 8'hFF;
    end else begin
      filtered_prev <= filtered;
      if (wr_hit) begin
        sel_q  <= din[P15_BIT:P14_BIT];
        settle <= SW'(SETTLE_CYCLES);
      end else if (settle != '0) begin
        settle <= settle - 1'b1;
      end
      if (irq_set)      int_req <= 1'b1;
      else if (int_ack) int_req <= 1'b0;
      if (rd_hit) dout <= p1_read_value(sel_q, filtered);
    end
  end

endmodule
